// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl: coprocessor-0-lite interrupt controller.
//   Samples device IRQ lines into CAUSE.IP, masks them with SR.IM and SR.IE,
//   and raises int_req to the CPU while EXL is clear. Holds SR, CAUSE, EPC
//   and PRID for mfc0/mtc0. Handles EXL entry (exl_set) and exit (exl_clr).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   hw_irq     device IRQ levels; bit 0 is Timer_IRQ
//   pc         word PC (PC[31:2]) to save in EPC on exception entry
//   cp0_sel    register select: 12 SR, 13 CAUSE, 14 EPC, 15 PRID
//   cp0_we     mtc0 write strobe
//   cp0_wdata  mtc0 data
//   cp0_rdata  mfc0 data, combinational on cp0_sel
//   exl_set    CPU takes an interrupt this cycle
//   exl_clr    eret executes this cycle
//   int_req    interrupt request to the CPU
//   epc_out    EPC register, for the eret PC mux
//
// Build option: CP0_IRQ_LATCH_EN makes IP bits sticky (set by hw_irq,
// cleared by write-1 to CAUSE[15:10]). Without it IP follows hw_irq one
// cycle late and CAUSE is read-only.
module cp0_irq_ctrl #(
  parameter int          NUM_IRQ   = 6,
  parameter logic [31:0] PRID_VAL  = 32'h0000_1827,
  parameter logic [31:0] EPC_RESET = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] hw_irq,
  input  logic [29:0]        pc,
  input  logic [4:0]         cp0_sel,
  input  logic               cp0_we,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  input  logic               exl_set,
  input  logic               exl_clr,
  output logic               int_req,
  output logic [31:0]        epc_out
);

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;
  // IP and IM share the same bit positions in CAUSE and SR.
  localparam int         FLD_LSB   = 10;

  logic [NUM_IRQ-1:0] im_q, im_d;
  logic [NUM_IRQ-1:0] ip_q, ip_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  logic [31:0]        epc_q, epc_d;

  logic sr_wr, epc_wr;

  assign sr_wr  = cp0_we && (cp0_sel == SEL_SR);
  assign epc_wr = cp0_we && (cp0_sel == SEL_EPC);

  always_comb begin
    im_d  = im_q;
    ie_d  = ie_q;
    exl_d = exl_q;
    epc_d = epc_q;

    if (sr_wr) begin
      im_d = cp0_wdata[FLD_LSB +: NUM_IRQ];
      ie_d = cp0_wdata[0];
    end

    // exl_set beats exl_clr beats the SR write for EXL only; IM/IE above
    // still take a same-cycle SR write.
    if (exl_set)      exl_d = 1'b1;
    else if (exl_clr) exl_d = 1'b0;
    else if (sr_wr)   exl_d = cp0_wdata[1];

    // Exception entry captures the resume PC even over a same-cycle mtc0 EPC.
    if (exl_set)     epc_d = {pc, 2'b00};
    else if (epc_wr) epc_d = cp0_wdata;
  end

`ifdef CP0_IRQ_LATCH_EN
  logic               cause_wr;
  logic [NUM_IRQ-1:0] ip_clr;

  assign cause_wr = cp0_we && (cp0_sel == SEL_CAUSE);
  assign ip_clr   = cause_wr ? cp0_wdata[FLD_LSB +: NUM_IRQ] : '0;
  // OR-in after the clear so a same-edge device assertion is never lost.
  assign ip_d     = (ip_q & ~ip_clr) | hw_irq;
`else
  assign ip_d     = hw_irq;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q  <= '0;
      ip_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      epc_q <= EPC_RESET;
    end else begin
      im_q  <= im_d;
      ip_q  <= ip_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      epc_q <= epc_d;
    end
  end

  // Registers only: hw_irq reaches int_req through ip_q, never directly.
  assign int_req = (|(ip_q & im_q)) & ie_q & ~exl_q;
  assign epc_out = epc_q;

  always_comb begin
    cp0_rdata = 32'h0;
    unique case (cp0_sel)
      SEL_SR: begin
        cp0_rdata[FLD_LSB +: NUM_IRQ] = im_q;
        cp0_rdata[1]                  = exl_q;
        cp0_rdata[0]                  = ie_q;
      end
      SEL_CAUSE: cp0_rdata[FLD_LSB +: NUM_IRQ] = ip_q;
      SEL_EPC:   cp0_rdata = epc_q;
      SEL_PRID:  cp0_rdata = PRID_VAL;
      default:   cp0_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
module tb_cp0_irq_ctrl;

  localparam logic [31:0] PRID = 32'h0000_1827;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hw_irq;
  logic [29:0] pc;
  logic [4:0]  cp0_sel;
  logic        cp0_we;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exl_set;
  logic        exl_clr;
  logic        int_req;
  logic [31:0] epc_out;

  cp0_irq_ctrl dut (
    .clk(clk), .reset(reset), .hw_irq(hw_irq), .pc(pc),
    .cp0_sel(cp0_sel), .cp0_we(cp0_we), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .exl_set(exl_set), .exl_clr(exl_clr),
    .int_req(int_req), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  // Architectural state as the programmer sees it.
  bit          m_ip [6];
  bit          m_im [6];
  bit          m_ie, m_exl;
  logic [31:0] m_epc;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] rdata;
    logic        irq;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) begin m_ip[i] = 0; m_im[i] = 0; end
    m_ie = 0; m_exl = 0; m_epc = 32'h0;
  endfunction

  // Apply one clock edge of CP0 rules to the model using the inputs that
  // were present at that edge.
  function automatic void model_step();
    bit sr_w, ep_w, ca_w;
    if (reset) begin model_reset(); return; end
    sr_w = cp0_we && cp0_sel == 5'd12;
    ep_w = cp0_we && cp0_sel == 5'd14;
    ca_w = cp0_we && cp0_sel == 5'd13;
    for (int i = 0; i < 6; i++) begin
`ifdef CP0_IRQ_LATCH_EN
      if (hw_irq[i])                         m_ip[i] = 1;
      else if (ca_w && cp0_wdata[10 + i])    m_ip[i] = 0;
`else
      m_ip[i] = hw_irq[i];
`endif
      if (sr_w) m_im[i] = cp0_wdata[10 + i];
    end
    if (ca_w) begin end
    if (sr_w) m_ie = cp0_wdata[0];
    if (exl_set)      m_exl = 1;
    else if (exl_clr) m_exl = 0;
    else if (sr_w)    m_exl = cp0_wdata[1];
    if (exl_set)   m_epc = pc * 4;
    else if (ep_w) m_epc = cp0_wdata;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    bit   pend = 0;
    e.sel = cp0_sel;
    e.epc = m_epc;
    for (int i = 0; i < 6; i++) if (m_ip[i] && m_im[i]) pend = 1;
    e.irq = pend && m_ie && !m_exl;
    e.rdata = 32'h0;
    case (cp0_sel)
      5'd12: begin
        for (int i = 0; i < 6; i++) e.rdata += m_im[i] ? (32'd1 << (10 + i)) : 32'd0;
        e.rdata += (m_exl ? 32'd2 : 32'd0) + (m_ie ? 32'd1 : 32'd0);
      end
      5'd13: for (int i = 0; i < 6; i++) e.rdata += m_ip[i] ? (32'd1 << (10 + i)) : 32'd0;
      5'd14: e.rdata = m_epc;
      5'd15: e.rdata = PRID;
      default: e.rdata = 32'h0;
    endcase
    return e;
  endfunction

  // One cycle: let the edge happen, advance the model, drive new inputs,
  // then queue what the DUT must show until the next edge.
  task automatic drive(input logic rst, input logic [4:0] sel, input logic we,
                       input logic [31:0] wd, input logic [5:0] hw,
                       input logic [29:0] p, input logic set, input logic clr);
    @(posedge clk);
    model_step();
    #1;
    reset = rst; cp0_sel = sel; cp0_we = we; cp0_wdata = wd;
    hw_irq = hw; pc = p; exl_set = set; exl_clr = clr;
    if (rst) model_reset();
    exp_q.push_back(model_expect());
  endtask

  // Monitor: compare every queued expectation half a cycle after it is set.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("rdata[sel=%0d]", e.sel), cp0_rdata, e.rdata);
        check("int_req", {31'b0, int_req}, {31'b0, e.irq});
        check("epc_out", epc_out, e.epc);
      end
    end
  end

  initial begin
    logic [5:0] hw;
    logic [4:0] sel;
    logic [4:0] sels [6];
    sels = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd31};

    reset = 1; cp0_sel = 5'd12; cp0_we = 0; cp0_wdata = 0;
    hw_irq = 0; pc = 0; exl_set = 0; exl_clr = 0;
    model_reset();

    // Reset state, then release.
    drive(1, 5'd12, 0, 0, 6'h3f, 0, 0, 0);
    drive(1, 5'd13, 0, 0, 6'h3f, 0, 0, 0);
    drive(0, 5'd15, 0, 0, 0, 0, 0, 0);

    // Timer on IM[0] with IE; hw_irq[0] rises.
    drive(0, 5'd12, 1, 32'h0000_0401, 0, 0, 0, 0);
    drive(0, 5'd13, 0, 0, 6'b000001, 0, 0, 0);
    drive(0, 5'd13, 0, 0, 6'b000001, 30'h0000_0C05, 0, 0);
    // Exception entry, then eret with the line still high.
    drive(0, 5'd14, 0, 0, 6'b000001, 30'h0000_0C05, 1, 0);
    drive(0, 5'd12, 0, 0, 6'b000001, 0, 0, 0);
    drive(0, 5'd12, 0, 0, 6'b000001, 0, 0, 1);
    drive(0, 5'd12, 0, 0, 6'b000001, 0, 0, 0);

    // Only IM[1] enabled.
    drive(0, 5'd12, 1, 32'h0000_0801, 6'b000001, 0, 0, 0);
    drive(0, 5'd13, 0, 0, 6'b000001, 0, 0, 0);
    drive(0, 5'd13, 0, 0, 6'b000010, 0, 0, 0);
    drive(0, 5'd13, 0, 0, 6'b000010, 0, 0, 0);

    // exl_set overrides mtc0 EPC; then set+clr together.
    drive(0, 5'd14, 1, 32'hDEAD_BEEC, 6'b000010, 30'h1, 1, 0);
    drive(0, 5'd12, 0, 0, 0, 0, 0, 0);
    drive(0, 5'd12, 0, 0, 0, 30'h0000_0C05, 1, 1);
    drive(0, 5'd14, 0, 0, 0, 0, 0, 0);

    // Async reset mid-cycle with EXL=1.
    @(posedge clk);
    model_step();
    #1;
    cp0_sel = 5'd12; exl_set = 0; exl_clr = 0; cp0_we = 0;
    #2;
    reset = 1;
    model_reset();
    exp_q.push_back(model_expect());
    drive(1, 5'd13, 0, 0, 0, 0, 0, 0);
    drive(0, 5'd14, 0, 0, 0, 0, 0, 0);

    // Single-cycle pulse on hw_irq[2], then W1C on CAUSE.
    drive(0, 5'd12, 1, 32'h0000_1001, 0, 0, 0, 0);
    drive(0, 5'd13, 0, 0, 6'b000100, 0, 0, 0);
    drive(0, 5'd13, 0, 0, 0, 0, 0, 0);
    drive(0, 5'd13, 0, 0, 0, 0, 0, 0);
    drive(0, 5'd13, 1, 32'h0000_1000, 0, 0, 0, 0);
    drive(0, 5'd13, 0, 0, 0, 0, 0, 0);
    // Same-edge set versus clear.
    drive(0, 5'd13, 1, 32'h0000_fc00, 6'b000100, 0, 0, 0);
    drive(0, 5'd13, 0, 0, 0, 0, 0, 0);

    // Random traffic.
    hw = 0;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] wd;
      logic we, set, clr, rst;
      if ($urandom_range(3) == 0) hw = 6'($urandom);
      sel = sels[$urandom_range(5)];
      if ($urandom_range(7) == 0) sel = 5'($urandom);
      we  = ($urandom_range(2) == 0);
      wd  = $urandom;
      if ($urandom_range(1) == 0) wd[0] = 1'b1;
      set = ($urandom_range(9) == 0);
      clr = ($urandom_range(7) == 0);
      rst = ($urandom_range(99) == 0);
      drive(rst, sel, we, wd, ($urandom_range(5) == 0) ? 6'($urandom) : hw,
            30'($urandom), set, clr);
    end

    drive(0, 5'd12, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
